jt51_lfo_bank: RTL and testbench

Multi-channel, parametrised low-frequency oscillator bank for the JT51 family. It holds `CH` independent LFO channels, each with its own frequency, AM depth, PM depth and waveform. One shared arithmetic path serves the channels round-robin, one channel per `cen` tick. Each channel drives its AM/PM modulation values to the operator pipeline.

---
 rtl/jt51_lfo_pkg.sv | 35 +++
 rtl/jt51_lfo_bank_if.sv | 36 +++
 rtl/jt51_lfo_shape.sv | 33 +++
 rtl/jt51_lfo_bank.sv | 157 +++++++++++++++
 tb/tb_jt51_lfo_bank.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/jt51_lfo_pkg.sv
// Shared types, LFSR constants and helpers for the JT51 LFO bank.
package jt51_lfo_pkg;

   typedef enum logic [1:0] {
      SAW    = 2'd0,
      SQUARE = 2'd1,
      TRIANG = 2'd2,
      NOISE  = 2'd3
   } lfo_wave_e;

   localparam int                LFSR_W      = 17;
   localparam logic [LFSR_W-1:0] LFSR_SEED   = 17'h1;
   localparam int                LFSR_TAP_HI = 16;
   localparam int                LFSR_TAP_LO = 13;

   // One serviced channel's result, held for a single cen before reaching the outputs
   typedef struct packed {
      logic       wrap;
      logic [7:0] am;
      logic [7:0] pm;
   } lfo_res_t;

   function automatic logic [31:0] lfo_inc(input logic [7:0] freq, input int pw);
      logic [31:0] v;
      v = (freq == 8'd0) ? 32'd0 : ({27'd0, 1'b1, freq[3:0]} << freq[7:4]);
      if (pw < 32) v = v & ((32'd1 << pw) - 32'd1);
      return v;
   endfunction

   // x^17 + x^14 + 1, shifting towards the MSB
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/jt51_lfo_bank_if.sv
// Control, config-write and modulation-output bundle of the LFO bank.
// The sync vector exists only when JT51_LFO_SYNC_EN is defined.
interface jt51_lfo_bank_if #(
   parameter int CH = 2,
   parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
   logic                cen;
   logic                wr;
   logic [CW-1:0]       wr_ch;
   logic [1:0]          wr_sel;
   logic [7:0]          wr_data;
`ifdef JT51_LFO_SYNC_EN
   logic [CH-1:0]       sync;
`endif
   logic [CH-1:0]       lfo_clk;
   logic [8*CH-1:0]     am;
   logic [8*CH-1:0]     pm;
   logic                out_valid;
   logic [CW-1:0]       out_ch;

   modport master (
      output cen, wr, wr_ch, wr_sel, wr_data,
`ifdef JT51_LFO_SYNC_EN
      output sync,
`endif
      input  lfo_clk, am, pm, out_valid, out_ch
   );

   modport slave (
      input  cen, wr, wr_ch, wr_sel, wr_data,
`ifdef JT51_LFO_SYNC_EN
      input  sync,
`endif
      output lfo_clk, am, pm, out_valid, out_ch
   );
endinterface

// File: rtl/jt51_lfo_shape.sv
// Waveform lookup and AM/PM depth scaling for one LFO phase sample.
module jt51_lfo_shape
   import jt51_lfo_pkg::*;
(
   input  logic [7:0] p_i,
   input  lfo_wave_e  wave_i,
   input  logic [7:0] noise_i,
   input  logic [6:0] amd_i,
   input  logic [6:0] pmd_i,
   output logic [7:0] am_o,
   output logic [7:0] pm_o
);
   logic [7:0]         w;
   logic [15:0]        am_prod;
   logic signed [15:0] pm_prod;

   always_comb begin
      unique case (wave_i)
         SAW:     w = p_i;
         SQUARE:  w = p_i[7] ? 8'h00 : 8'hFF;
         TRIANG:  w = p_i[7] ? ~{p_i[6:0], 1'b0} : {p_i[6:0], 1'b0};
         default: w = noise_i;
      endcase
   end

   // PM treats the sample as offset-binary, centred on 0x80
   assign am_prod = {8'd0, w} * {9'd0, amd_i};
   assign pm_prod = $signed(w ^ 8'h80) * $signed({1'b0, pmd_i});

   assign am_o = 8'(am_prod >> 7);
   assign pm_o = (pmd_i == 7'd0) ? 8'h00 : 8'(pm_prod >>> 7);

endmodule

// File: rtl/jt51_lfo_bank.sv
// CH-channel LFO bank: one phase/shape datapath shared round-robin, one channel per cen.
// Define JT51_LFO_SYNC_EN to add per-channel sync inputs that zero a channel's phase.
module jt51_lfo_bank
   import jt51_lfo_pkg::*;
#(
   parameter int CH = 2,
   parameter int PW = 24,
   parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   jt51_lfo_bank_if.slave bus
);
   // per-channel configuration
   logic [7:0]    freq_q  [CH];
   logic [6:0]    amd_q   [CH];
   logic [6:0]    pmd_q   [CH];
   lfo_wave_e     wave_q  [CH];
   logic          wr_ok;

   // per-channel oscillator state and shared LFSR
   logic [PW-1:0]     phase_q [CH];
   logic [7:0]        noise_q [CH];
   logic [LFSR_W-1:0] lfsr_q;
   logic [CW-1:0]     slot_q, slot_d;

   // shared service datapath
   logic [PW-1:0] inc;
   logic [PW:0]   sum;
   logic          wrap;
   logic [PW-1:0] nphase;
   logic [7:0]    nnoise;
   logic [7:0]    shp_am, shp_pm;

   // result stage and output registers
   logic [1:0]          vld_pipe_q;
   lfo_res_t            res_q, res_d;
   logic [CW-1:0]       res_ch_q, out_ch_q;
   logic [CH-1:0]       lfo_clk_q, lfo_clk_d;
   logic [CH-1:0][7:0]  am_q, pm_q;

`ifdef JT51_LFO_SYNC_EN
   logic [CH-1:0] pend_q, pend_d;

   // a sync landing on the serviced channel's own tick survives to the next visit
   always_comb begin
      pend_d = pend_q;
      if (bus.cen) pend_d[slot_q] = 1'b0;
      pend_d = pend_d | bus.sync;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end
`endif

   assign wr_ok = bus.wr && (int'(bus.wr_ch) < CH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            freq_q[i] <= '0;
            amd_q[i]  <= '0;
            pmd_q[i]  <= '0;
            wave_q[i] <= SAW;
         end
      end else if (wr_ok) begin
         unique case (bus.wr_sel)
            2'd0:    freq_q[bus.wr_ch] <= bus.wr_data;
            2'd1:    amd_q[bus.wr_ch]  <= bus.wr_data[6:0];
            2'd2:    pmd_q[bus.wr_ch]  <= bus.wr_data[6:0];
            default: wave_q[bus.wr_ch] <= lfo_wave_e'(bus.wr_data[1:0]);
         endcase
      end
   end

   assign slot_d = (int'(slot_q) == CH - 1) ? '0 : slot_q + 1'b1;

   // noise byte reloads on wrap and that same tick's sample already sees the new byte
   always_comb begin
      inc    = PW'(lfo_inc(freq_q[slot_q], PW));
      sum    = {1'b0, phase_q[slot_q]} + {1'b0, inc};
      wrap   = sum[PW];
      nphase = sum[PW-1:0];
      nnoise = wrap ? lfsr_q[7:0] : noise_q[slot_q];
`ifdef JT51_LFO_SYNC_EN
      if (pend_q[slot_q]) begin
         nphase = '0;
         nnoise = '0;
         wrap   = 1'b0;
      end
`endif
   end

   jt51_lfo_shape u_shape (
      .p_i     (nphase[PW-1 -: 8]),
      .wave_i  (wave_q[slot_q]),
      .noise_i (nnoise),
      .amd_i   (amd_q[slot_q]),
      .pmd_i   (pmd_q[slot_q]),
      .am_o    (shp_am),
      .pm_o    (shp_pm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         lfsr_q <= LFSR_SEED;
         for (int i = 0; i < CH; i++) begin
            phase_q[i] <= '0;
            noise_q[i] <= '0;
         end
      end else if (bus.cen) begin
         slot_q          <= slot_d;
         lfsr_q          <= lfsr_step(lfsr_q);
         phase_q[slot_q] <= nphase;
         noise_q[slot_q] <= nnoise;
      end
   end

   always_comb begin
      res_d = '{wrap: wrap, am: shp_am, pm: shp_pm};
      lfo_clk_d = '0;
      if (vld_pipe_q[0] && res_q.wrap) lfo_clk_d[res_ch_q] = 1'b1;
   end

   // results surface one cen after their service tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         res_q      <= '0;
         res_ch_q   <= '0;
         out_ch_q   <= '0;
         lfo_clk_q  <= '0;
         am_q       <= '0;
         pm_q       <= '0;
      end else if (bus.cen) begin
         vld_pipe_q <= {vld_pipe_q[0], 1'b1};
         res_q      <= res_d;
         res_ch_q   <= slot_q;
         out_ch_q   <= res_ch_q;
         lfo_clk_q  <= lfo_clk_d;
         if (vld_pipe_q[0]) begin
            am_q[res_ch_q] <= res_q.am;
            pm_q[res_ch_q] <= res_q.pm;
         end
      end
   end

   assign bus.lfo_clk   = lfo_clk_q;
   assign bus.am        = am_q;
   assign bus.pm        = pm_q;
   assign bus.out_valid = vld_pipe_q[1];
   assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_jt51_lfo_bank.sv
// Randomised bench for jt51_lfo_bank against an arithmetic reference model of the LFO rules.
module tb_jt51_lfo_bank;
   localparam int CH = 3;
   localparam int PW = 24;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jt51_lfo_bank_if #(.CH(CH), .CW(CW)) bus ();
   jt51_lfo_bank #(.CH(CH), .PW(PW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference model state
   longint m_phase [CH];
   int     m_freq [CH], m_amd [CH], m_pmd [CH], m_wave [CH], m_noise [CH];
   bit     m_pend [CH];
   int     m_lfsr, m_slot;
   bit     r_vld, r_wrap;
   int     r_ch, r_am, r_pm;
   int     e_am [CH], e_pm [CH];
   int     e_lclk, e_ch;
   bit     e_vld;

   function automatic void check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int m_inc(input int f);
      return (f == 0) ? 0 : ((16 + f % 16) << (f / 16));
   endfunction

   function automatic int m_sample(input int p, input int wv, input int nz);
      case (wv)
         0:       return p;
         1:       return (p >= 128) ? 0 : 255;
         2:       return (p >= 128) ? 255 - 2 * (p - 128) : 2 * p;
         default: return nz;
      endcase
   endfunction

   function automatic int m_am_of(input int w, input int a);
      return (w * a) / 128;
   endfunction

   function automatic int m_pm_of(input int w, input int d);
      int s, q;
      s = (w - 128) * d;
      q = (s >= 0) ? s / 128 : -((-s + 127) / 128);
      return q & 255;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < CH; i++) begin
         m_phase[i] = 0; m_freq[i] = 0; m_amd[i] = 0; m_pmd[i] = 0;
         m_wave[i] = 0; m_noise[i] = 0; m_pend[i] = 0; e_am[i] = 0; e_pm[i] = 0;
      end
      m_lfsr = 1; m_slot = 0;
      r_vld = 0; r_wrap = 0; r_ch = 0; r_am = 0; r_pm = 0;
      e_lclk = 0; e_ch = 0; e_vld = 0;
   endfunction

   function automatic void m_tick();
      longint sum;
      bit     wr;
      int     s, p, w;
      if (r_vld) begin
         e_am[r_ch] = r_am;
         e_pm[r_ch] = r_pm;
      end
      e_vld  = r_vld;
      e_ch   = r_ch;
      e_lclk = (r_vld && r_wrap) ? (1 << r_ch) : 0;
      s   = m_slot;
      sum = m_phase[s] + longint'(m_inc(m_freq[s]));
      wr  = (sum >= (64'd1 << PW));
      m_phase[s] = sum % (64'd1 << PW);
      if (wr) m_noise[s] = m_lfsr & 255;
      if (m_pend[s]) begin
         m_phase[s] = 0; m_noise[s] = 0; wr = 0; m_pend[s] = 0;
      end
      p = int'(m_phase[s] >> (PW - 8));
      w = m_sample(p, m_wave[s], m_noise[s]);
      r_vld = 1; r_wrap = wr; r_ch = s;
      r_am = m_am_of(w, m_amd[s]);
      r_pm = m_pm_of(w, m_pmd[s]);
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1)) & 32'h1FFFF;
      m_slot = (s + 1) % CH;
   endfunction

   function automatic void m_write(input int ch, input int sel, input int d);
      if (ch >= CH) return;
      case (sel)
         0:       m_freq[ch] = d;
         1:       m_amd[ch]  = d & 127;
         2:       m_pmd[ch]  = d & 127;
         default: m_wave[ch] = d & 3;
      endcase
   endfunction

   task automatic cycle(input bit c, input bit w, input int wch, input int wsel,
                        input int wd, input int sy);
      @(negedge clk);
      bus.cen     = c;
      bus.wr      = w;
      bus.wr_ch   = CW'(wch);
      bus.wr_sel  = 2'(wsel);
      bus.wr_data = 8'(wd);
`ifdef JT51_LFO_SYNC_EN
      bus.sync    = CH'(sy);
`endif
      @(posedge clk);
      if (c) m_tick();
      if (w) m_write(wch, wsel, wd);
`ifdef JT51_LFO_SYNC_EN
      for (int n = 0; n < CH; n++) if ((sy >> n) & 1) m_pend[n] = 1'b1;
`else
      if (sy < 0) $display("unexpected sync value %0d", sy);
`endif
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", int'(bus.out_valid), int'(e_vld));
         check("out_ch", int'(bus.out_ch), e_ch);
         check("lfo_clk", int'(bus.lfo_clk), e_lclk);
         for (int n = 0; n < CH; n++) begin
            check($sformatf("am[%0d]", n), int'(bus.am[8*n +: 8]), e_am[n]);
            check($sformatf("pm[%0d]", n), int'(bus.pm[8*n +: 8]), e_pm[n]);
         end
      end
   end

   initial begin
      int pulses [$];
      int max_am0, guard, wsel, wd, sy;

      bus.cen = 0; bus.wr = 0; bus.wr_ch = '0; bus.wr_sel = '0; bus.wr_data = '0;
`ifdef JT51_LFO_SYNC_EN
      bus.sync = '0;
`endif
      m_reset();

      // pin the model's arithmetic with hand-worked values
      check("model_inc80", m_inc(8'h80), 4096);
      check("model_am_max", m_am_of(255, 127), 8'hFD);
      check("model_pm_hi", m_pm_of(255, 127), 8'h7E);
      check("model_pm_lo", m_pm_of(0, 127), 8'h81);
      check("model_tri_up", m_sample(8'h40, 2, 0), 8'h80);
      check("model_tri_dn", m_sample(8'hC8, 2, 0), 8'h6F);

      repeat (3) @(negedge clk);
      check("rst_am", int'(bus.am), 0);
      check("rst_pm", int'(bus.pm), 0);
      check("rst_lfo_clk", int'(bus.lfo_clk), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      cycle(1, 0, 0, 0, 0, 0);
      check("first_cen_valid", int'(bus.out_valid), 0);
      cycle(1, 0, 0, 0, 0, 0);
      check("second_cen_valid", int'(bus.out_valid), 1);
      check("second_cen_ch", int'(bus.out_ch), 0);

      // ch0 saw ramp, ch1 square at full PM depth
      cycle(0, 1, 0, 0, 8'h80, 0);
      cycle(0, 1, 0, 1, 127, 0);
      cycle(0, 1, 0, 3, 0, 0);
      cycle(0, 1, 1, 0, 8'hF0, 0);
      cycle(0, 1, 1, 3, 1, 0);
      cycle(0, 1, 1, 2, 127, 0);

      max_am0 = 0;
      for (int t = 0; t < 24600; t++) begin
         cycle(1, 0, 0, 0, 0, 0);
         if (bus.lfo_clk[0]) pulses.push_back(t);
         if (int'(bus.am[7:0]) > max_am0) max_am0 = int'(bus.am[7:0]);
      end
      check("ramp_max_am", max_am0, 8'hFD);
      check("lfo_clk0_pulses", pulses.size(), 2);
      if (pulses.size() >= 2) check("lfo_clk0_period", pulses[1] - pulses[0], 4096 * CH);

      // amd write landing on ch0's own service tick
      guard = 0;
      while (m_slot != 0 && guard < 2 * CH) begin
         cycle(1, 0, 0, 0, 0, 0);
         guard++;
      end
      check("slot_align", m_slot, 0);
      cycle(1, 1, 0, 1, 64, 0);
      repeat (2 * CH) cycle(1, 0, 0, 0, 0, 0);

      // out-of-range channel writes
      for (int s = 0; s < 4; s++) cycle(0, 1, CH, s, 8'hFF, 0);

      cycle(0, 1, 1, 2, 0, 0);
      repeat (2 * CH) cycle(1, 0, 0, 0, 0, 0);
      check("pmd0_pm1", int'(bus.pm[15:8]), 0);

      // asynchronous reset in the middle of operation
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_am", int'(bus.am), 0);
      check("arst_pm", int'(bus.pm), 0);
      check("arst_lfo_clk", int'(bus.lfo_clk), 0);
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_out_ch", int'(bus.out_ch), 0);
      m_reset();
      repeat (3) cycle(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 30000; t++) begin
         wsel = $urandom % 4;
         wd   = (wsel == 0) ? int'(($urandom_range(15, 6) << 4) | ($urandom % 16))
                            : int'($urandom % 256);
         sy   = ($urandom % 64 == 0) ? int'($urandom % (1 << CH)) : 0;
         cycle(($urandom % 4) != 0, ($urandom % 16) == 0, int'($urandom % 4), wsel, wd, sy);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
